// File: rtl/uart_bridge_pkg.sv
// Shared types and defaults for the UART-AXI4 bridge transmit path.
// Holds the frame arbiter state enum, default sizing constants and width helper.
package uart_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2,
      GAP   = 2'd3
   } arb_state_e;

   localparam int DEF_IDLE_GAP_CYCLES = 16;
   localparam int DEF_MAX_FRAME_BYTES = 64;

   // Requester index width; never narrower than one bit.
   function automatic int gid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_cts_sync.sv
// N-flop synchronizer for the asynchronous active-low CTS pin.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out); resets to 1.
module uart_cts_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] s;

   // Reset to 1 so the line reads as "not clear to send" until sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s <= '1;
      end else begin
         s <= {s[N-2:0], d};
      end
   end

   assign q = s[N-1];

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin whole-frame arbiter in front of the UART TX serializer.
// Ports: req_* byte streams in, tx_* byte out, tx_busy/uart_cts_n line state, status outputs.
module uart_tx_frame_arbiter
   import uart_bridge_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int CTS_SYNC_STAGES = 2,
   parameter int MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES,
   parameter int IDLE_GAP_CYCLES = DEF_IDLE_GAP_CYCLES,
   localparam int GW             = gid_width(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   input  logic                 tx_busy,
   input  logic                 uart_cts_n,
   output logic [GW-1:0]        grant_id,
   output logic                 arb_busy,
   output logic                 frame_trunc,
   output logic                 cts_stalled
);

   localparam int CW = $clog2(MAX_FRAME_BYTES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_BYTES);

   localparam int GCW = (IDLE_GAP_CYCLES > 1) ? $clog2(IDLE_GAP_CYCLES) : 1;
   localparam int GLAST = (IDLE_GAP_CYCLES > 1) ? IDLE_GAP_CYCLES - 1 : 0;
   localparam logic [GCW-1:0] GLAST_V = GCW'(GLAST);
   localparam bit SHORT_GAP = (IDLE_GAP_CYCLES <= 1);

   arb_state_e     state;
   logic [GW-1:0]  ptr;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nx;
   logic           eof_loaded;
   logic [GCW-1:0] gap_cnt;

   logic           cts_q;
   logic           cts_ok;
   logic           g_valid;
   logic           g_last;
   logic [7:0]     g_data;
   logic           out_free;
   logic           load_ok;
   logic           accept;
   logic           hit_max;
   logic           line_idle;
   logic           gap_done;
   logic [GW-1:0]  ptr_nx;

   // First requester at or after the pointer, wrapping around.
   function automatic logic [GW-1:0] rr_pick(
      input logic [NUM_REQ-1:0] v,
      input logic [GW-1:0]      p
   );
      logic [GW-1:0] g;
      logic [GW-1:0] idx_l;
      logic          found;
      int            idx;
      g     = p;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx   = (int'(p) + i) % NUM_REQ;
         idx_l = GW'(idx);
         if (!found && v[idx_l]) begin
            g     = idx_l;
            found = 1'b1;
         end
      end
      return g;
   endfunction

   uart_cts_sync #(
      .N (CTS_SYNC_STAGES)
   ) u_cts_sync (
      .clk (clk),
      .rst (rst),
      .d   (uart_cts_n),
      .q   (cts_q)
   );

   assign cts_ok  = !cts_q;

   assign g_valid = req_valid[grant_id];
   assign g_last  = req_last[grant_id];
   assign g_data  = req_data[{grant_id, 3'b000} +: 8];

   // Output register can take a new byte when empty or draining this cycle.
   assign out_free = !tx_valid || tx_ready;
   assign load_ok  = (state == XFER) && cts_ok && out_free && !eof_loaded;
   assign accept   = load_ok && g_valid;
   assign cnt_nx   = cnt + CW'(1);
   assign hit_max  = (cnt_nx == CNT_MAX);

   always_comb begin
      req_ready           = '0;
      req_ready[grant_id] = load_ok;
   end

   assign frame_trunc = accept && hit_max && !g_last;
   assign cts_stalled = (state == XFER) && !cts_ok;
   assign arb_busy    = (state != IDLE);

   assign ptr_nx = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

   // The DRAIN cycle that first sees an idle line is the first gap cycle,
   // so GAP itself only has to cover the remaining IDLE_GAP_CYCLES-1.
   assign line_idle = !tx_busy && !tx_valid;
   assign gap_done  = ((state == DRAIN) && line_idle && SHORT_GAP) ||
                      ((state == GAP) && (gap_cnt >= GLAST_V));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         grant_id   <= '0;
         cnt        <= '0;
         eof_loaded <= 1'b0;
         gap_cnt    <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant_id <= rr_pick(req_valid, ptr);
                  state    <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  tx_valid <= 1'b1;
                  tx_data  <= g_data;
                  cnt      <= cnt_nx;
                  if (g_last || hit_max) begin
                     eof_loaded <= 1'b1;
                  end
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
               end
               if (eof_loaded && out_free) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (line_idle && !SHORT_GAP) begin
                  gap_cnt <= GCW'(1);
                  state   <= GAP;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + GCW'(1);
            end
         endcase
         if (gap_done) begin
            state      <= IDLE;
            ptr        <= ptr_nx;
            cnt        <= '0;
            eof_loaded <= 1'b0;
            gap_cnt    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Scoreboard bench for uart_tx_frame_arbiter with two requesters.
// Directed frames feed source queues; expected tx bytes are queued by hand.
module tb_uart_tx_frame_arbiter;

   localparam int NR   = 2;
   localparam int CS   = 2;
   localparam int MFB  = 64;
   localparam int GAPC = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req_valid;
   logic [NR*8-1:0] req_data;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_ready;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic          tx_busy;
   logic          uart_cts_n;
   logic [0:0]    grant_id;
   logic          arb_busy;
   logic          frame_trunc;
   logic          cts_stalled;

   always #5 clk = ~clk;

   uart_tx_frame_arbiter #(
      .NUM_REQ         (NR),
      .CTS_SYNC_STAGES (CS),
      .MAX_FRAME_BYTES (MFB),
      .IDLE_GAP_CYCLES (GAPC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .uart_cts_n  (uart_cts_n),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .frame_trunc (frame_trunc),
      .cts_stalled (cts_stalled)
   );

   // Source queues hold {last, data}; expected queue holds {grant, data}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] exp_q[$];

   int         vec = 0;
   int         err = 0;
   int         trunc_seen = 0;
   logic [7:0] trunc_exp = 8'h00;
   int         busy_cnt = 0;

   // Serializer model: busy for a few cycles after each accepted byte.
   always @(posedge clk) begin
      if (rst) begin
         busy_cnt <= 0;
      end else if (tx_valid && tx_ready) begin
         busy_cnt <= 4;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign tx_busy = (busy_cnt != 0);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      vec++;
      if (act !== req) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic push_src(input int r, input int first, input int n,
                           input bit with_last);
      logic [8:0] e;
      for (int i = 0; i < n; i++) begin
         e = {with_last && (i == n - 1), 8'(first + i)};
         if (r == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   task automatic push_exp(input int r, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({1'(r), 8'(first + i)});
      end
   endtask

   task automatic wait_tx(input logic [7:0] d, input string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(tx_valid && tx_data == d) && k < 500);
      chk(nm, 32'(tx_valid && tx_data == d), 1);
   endtask

   task automatic wait_idle(input string nm);
      int   k;
      logic ok;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         ok = exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
              !arb_busy && !tx_valid;
      end while (!ok && k < 3000);
      chk(nm, 32'(ok), 1);
   endtask

   // Requester driver: present queue heads, pop on handshake.
   initial begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(posedge clk);
         #1;
         req_valid[0]   = q0.size() != 0;
         req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
         req_last[0]    = (q0.size() != 0) ? q0[0][8] : 1'b0;
         req_valid[1]   = q1.size() != 0;
         req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
         req_last[1]    = (q1.size() != 0) ? q1[0][8] : 1'b0;
         @(negedge clk);
         if (req_valid[0] && req_ready[0] && q0.size() != 0)
            void'(q0.pop_front());
         if (req_valid[1] && req_ready[1] && q1.size() != 0)
            void'(q1.pop_front());
      end
   end

   // Output monitor: scoreboard compare, hold stability, truncation point.
   initial begin
      logic       held;
      logic [7:0] hd;
      logic [8:0] e;
      held = 1'b0;
      hd   = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_valid", 32'(tx_valid), 1);
               chk("hold_data", 32'(tx_data), 32'(hd));
            end
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  vec++;
                  err++;
                  $display("FAIL unexpected_byte: got %02h expected none",
                           tx_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                  chk("grant_id", 32'(grant_id), 32'(e[8]));
               end
            end
            if (frame_trunc) begin
               trunc_seen++;
               chk("trunc_byte", 32'(req_data[7:0]), 32'(trunc_exp));
               chk("trunc_last", 32'(req_last[0]), 0);
            end
            held = tx_valid && !tx_ready;
            hd   = tx_data;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit hit, expected summary first");
      $fatal(1);
   end

   initial begin
      int k;
      rst        = 1'b1;
      tx_ready   = 1'b1;
      uart_cts_n = 1'b0;

      // Both requesters pending while reset is held.
      push_src(0, 8'hA0, 3, 1'b1);
      push_src(1, 8'hB0, 3, 1'b1);
      push_exp(0, 8'hA0, 3);
      push_exp(1, 8'hB0, 3);
      repeat (3) @(negedge clk);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_arb_busy", 32'(arb_busy), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_trunc", 32'(frame_trunc), 0);
      chk("rst_cts_stall", 32'(cts_stalled), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle("rr_first_round");

      // Pointer wrapped to 0: req0 wins the simultaneous request.
      push_src(0, 8'hC0, 3, 1'b1);
      push_src(1, 8'hD0, 3, 1'b1);
      push_exp(0, 8'hC0, 3);
      push_exp(1, 8'hD0, 3);
      wait_idle("rr_second_round");

      // Single 5-byte frame: latency and inter-frame gap.
      push_src(0, 8'h11, 5, 1'b1);
      push_exp(0, 8'h11, 5);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(req_valid[0] && req_ready[0]) && k < 100);
      chk("t1_accept_seen", 32'(req_valid[0] && req_ready[0]), 1);
      chk("t1_pre_valid", 32'(tx_valid), 0);
      @(negedge clk);
      chk("t1_lat_valid", 32'(tx_valid), 1);
      chk("t1_lat_data", 32'(tx_data), 32'h11);
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (tx_busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("t1_busy_fell", 32'(tx_busy), 0);
      chk("t1_arb_busy_at_fall", 32'(arb_busy), 1);
      k = 0;
      while (arb_busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("t1_gap_len", 32'(k), 32'(GAPC));
      wait_idle("t1_done");

      // CTS deasserted with byte 2 presented and tx_ready low.
      push_src(0, 8'h31, 2, 1'b0);
      push_exp(0, 8'h31, 6);
      wait_tx(8'h31, "t3_byte1_seen");
      @(posedge clk);
      #1;
      tx_ready   = 1'b0;
      uart_cts_n = 1'b1;
      push_src(0, 8'h33, 4, 1'b1);
      repeat (6) begin
         @(negedge clk);
         chk("t3_hold_ready", 32'(req_ready), 0);
      end
      chk("t3_hold_valid", 32'(tx_valid), 1);
      chk("t3_hold_data", 32'(tx_data), 32'h32);
      chk("t3_stalled", 32'(cts_stalled), 1);
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("t3_withheld", 32'(tx_valid), 0);
         chk("t3_stall_ready", 32'(req_ready), 0);
      end
      chk("t3_stalled2", 32'(cts_stalled), 1);
      @(posedge clk);
      #1 uart_cts_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_resume_early", 32'(tx_valid), 0);
      @(negedge clk);
      chk("t3_resume_valid", 32'(tx_valid), 1);
      chk("t3_resume_data", 32'(tx_data), 32'h33);
      wait_idle("t3_done");

      // Serializer back-pressure for 20 cycles mid-frame.
      push_src(0, 8'h51, 6, 1'b1);
      push_exp(0, 8'h51, 6);
      wait_tx(8'h52, "t5_byte2_seen");
      @(posedge clk);
      #1 tx_ready = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk("t5_valid", 32'(tx_valid), 1);
         chk("t5_data", 32'(tx_data), 32'h53);
         chk("t5_ready", 32'(req_ready), 0);
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle("t5_done");

      // 70 bytes with last only on byte 70: guard cuts at 64.
      trunc_exp = 8'd64;
      push_src(0, 1, 70, 1'b1);
      push_exp(0, 1, 70);
      k = 0;
      while (exp_q.size() > 6 && k < 500) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (arb_busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t4_idle_between", 32'(arb_busy), 0);
      chk("t4_withheld", 32'(q0.size()), 6);
      wait_idle("t4_done");
      chk("t4_trunc_count", 32'(trunc_seen), 1);

      // Reset while byte 3 of a requester-1 frame is presented.
      push_src(1, 8'h61, 6, 1'b1);
      push_exp(1, 8'h61, 6);
      wait_tx(8'h62, "t6_byte2_seen");
      chk("t6_grant_before", 32'(grant_id), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_tx_valid", 32'(tx_valid), 0);
      chk("t6_arb_busy", 32'(arb_busy), 0);
      chk("t6_grant", 32'(grant_id), 0);
      q1.delete();
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      push_src(1, 8'h71, 2, 1'b1);
      push_exp(1, 8'h71, 2);
      wait_idle("t6_after_reset");

      chk("end_exp_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
